rr_mux_4_1_stage: RTL
=====================

Name: rr_mux_4_1_stage

Overview:
- 4-source round-robin arbitrated stage that sits directly upstream of the 4:1 select mux datapath.
- Each source offers a W-bit word with a valid/ready handshake.
- The block grants one source per transfer in round-robin order and registers the selected word into a one-entry output stage.
- It also registers the 2-bit select code of the winning source, so downstream sees both the data and its origin.

Parameters:
W  4  data width of each source word and of y

Ports:
clk        input   1     clock, all state updates on rising edge
rst        input   1     synchronous reset, active-high
d0         input   W     source 0 data
d1         input   W     source 1 data
d2         input   W     source 2 data
d3         input   W     source 3 data
in_valid   input   4     per-source valid, bit i belongs to di
in_ready   output  4     per-source ready, bit i belongs to di (combinational)
y          output  W     registered output word
sel        output  2     registered index of the source that produced y
out_valid  output  1     y/sel hold a word
out_ready  input   1     downstream accepts y this cycle

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst); sampled on the rising edge only.
- Reset values: y = 0, sel = 2'b00, out_valid = 0, round-robin pointer ptr = 0.
- in_ready is 0 while rst is high.
- Transfer rules:
  - Source transfer occurs on a cycle with in_valid[i] & in_ready[i].
  - Output transfer occurs on a cycle with out_valid & out_ready.
  - Sources hold di and in_valid[i] stable while in_valid[i] & !in_ready[i].
- load_en = !out_valid | out_ready (output empty, or being drained this cycle).
- Grant, combinational:
  - Scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first index g with in_valid[g] = 1 wins.
  - No valid source means no grant.
- in_ready[i] = load_en & (grant == i).
  - At most one bit of in_ready is high per cycle.
  - in_ready depends combinationally on in_valid and out_ready; this path is accepted.
- On a source transfer at edge t:
  - y <= d[g], sel <= g, out_valid <= 1.
  - ptr <= g + 1 (mod 4; 3 wraps to 0).
- Latency: a word accepted at edge t is visible on y at edge t, one cycle after it was presented.
- Full throughput: a new word is accepted in the same cycle the old one drains.
- Output transfer with no source transfer in the same cycle: out_valid <= 0. y and sel keep their old values (don't-care while out_valid = 0).
- Simultaneous output drain and source accept: the new word replaces the old; out_valid stays 1.
- Output stall (out_valid & !out_ready): y, sel, ptr and out_valid hold; in_ready = 0.
- No valid sources: ptr does not change.
- A source that stays valid is re-granted only after every other valid source has been served once.
- Reset mid-operation: any word held in the output register is dropped, ptr returns to 0, and no transfer occurs in the reset cycle.

Test Plan:
- Single source:
  - Stimulus: reset, then in_valid = 4'b0100, d2 = 4'hA, out_ready = 1.
  - Required: in_ready = 4'b0100 in the first cycle; next cycle y = 4'hA, sel = 2'b10, out_valid = 1; ptr becomes 3.
- All sources valid every cycle:
  - Stimulus: d0..d3 = 1, 2, 3, 4; out_ready = 1.
  - Required: sel sequence 0,1,2,3,0,1...; y = 1,2,3,4,1...; out_valid continuously 1 after the first word.
- Backpressure:
  - Stimulus: all sources valid, out_ready held 0 for 3 cycles after the first word.
  - Required: y and sel frozen, in_ready = 0 during the stall; when out_ready returns to 1, the next grant is the following index.
- Wrap and skip:
  - Stimulus: ptr = 3 (after serving source 2), then in_valid = 4'b0011.
  - Required: source 0 is granted, then source 1, then source 0.
- Drain without refill:
  - Stimulus: one word is in the output stage; all in_valid = 0; out_ready = 1.
  - Required: out_valid drops to 0 the next cycle; in_ready stays 4'b0000.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle while out_valid = 1 and all sources are valid.
  - Required: out_valid = 0, y = 0, sel = 0, in_ready = 0 during the reset cycle; the first grant after reset is source 0.

Source files
------------

// File: rtl/rr_mux_4_1_stage.sv
// Round-robin arbitrated 4:1 stage: grants one valid source per transfer and registers its word plus its select code.
// Latency: one cycle from acceptance to y/sel/out_valid; full throughput (accept while draining).
// Backpressure: in_ready is driven only when the output slot is empty or being drained; a stalled output holds everything.
module rr_mux_4_1_stage #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [3:0]   in_valid,
  output logic [3:0]   in_ready,
  output logic [W-1:0] y,
  output logic [1:0]   sel,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] y_q, y_d;
  logic [1:0]   sel_q, sel_d;
  logic         out_valid_q, out_valid_d;
  logic [1:0]   ptr_q, ptr_d;

  logic         load_en;
  logic         gnt_vld;
  logic [1:0]   gnt;
  logic         src_xfer;
  logic [W-1:0] gnt_dat;

  // Output slot can take a word when empty or when its current word leaves this cycle.
  assign load_en = !out_valid_q || out_ready;

  // Scan sources starting at the round-robin pointer; the first valid one wins.
  always_comb begin
    logic [1:0] idx;
    gnt_vld = 1'b0;
    gnt     = ptr_q;
    idx     = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!gnt_vld && in_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  // One-hot ready toward the winner only; suppressed during reset so nothing transfers then.
  always_comb begin
    in_ready = 4'b0000;
    if (!rst && load_en && gnt_vld) begin
      in_ready = 4'b0001 << gnt;
    end
  end

  assign src_xfer = |in_ready;

  // Select the winning source's word for the output register.
  always_comb begin
    gnt_dat = d0;
    case (gnt)
      2'd0:    gnt_dat = d0;
      2'd1:    gnt_dat = d1;
      2'd2:    gnt_dat = d2;
      default: gnt_dat = d3;
    endcase
  end

  // Next-state: load on a source transfer, empty on a drain without refill, else hold.
  always_comb begin
    y_d         = y_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (src_xfer) begin
      y_d         = gnt_dat;
      sel_d       = gnt;
      out_valid_d = 1'b1;
      ptr_d       = gnt + 2'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; a held word is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= '0;
      sel_q       <= 2'b00;
      out_valid_q <= 1'b0;
      ptr_q       <= 2'b00;
    end else begin
      y_q         <= y_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign y         = y_q;
  assign sel       = sel_q;
  assign out_valid = out_valid_q;

endmodule
